// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX operand stage with forwarding, load-use stall and stall counter
module id_ex_operand_stage #(
    parameter int XLEN  = 32,
    parameter int AW    = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [AW-1:0]    id_rs1,
    input  logic [AW-1:0]    id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [AW-1:0]    id_rd,
    input  logic             id_rd_we,
    input  logic             id_is_load,
    input  logic [XLEN-1:0]  PA,
    input  logic [XLEN-1:0]  PB,
    input  logic [XLEN-1:0]  ex_result,
    input  logic [AW-1:0]    mem_rd,
    input  logic             mem_we,
    input  logic [XLEN-1:0]  mem_result,
    input  logic [AW-1:0]    wb_rd,
    input  logic             wb_we,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             flush,
    output logic             stall,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_op_a,
    output logic [XLEN-1:0]  ex_op_b,
    output logic [AW-1:0]    ex_rd,
    output logic             ex_rd_we,
    output logic             ex_is_load,
    output logic [1:0]       ex_fwd_a,
    output logic [1:0]       ex_fwd_b,
    output logic [CNT_W-1:0] stall_count
);

    logic [XLEN-1:0] op_a_nxt;
    logic [XLEN-1:0] op_b_nxt;
    logic [1:0]      fwd_a_nxt;
    logic [1:0]      fwd_b_nxt;
    logic            bubble;

    // Operand A source: x0, then youngest producer (EX) down to WB, else register file
    always_comb begin
        op_a_nxt  = PA;
        fwd_a_nxt = 2'd0;
        if (id_rs1 == '0) begin
            op_a_nxt  = '0;
            fwd_a_nxt = 2'd0;
        end else if (ex_valid && ex_rd_we && (ex_rd == id_rs1)) begin
            op_a_nxt  = ex_result;
            fwd_a_nxt = 2'd1;
        end else if (mem_we && (mem_rd == id_rs1)) begin
            op_a_nxt  = mem_result;
            fwd_a_nxt = 2'd2;
        end else if (wb_we && (wb_rd == id_rs1)) begin
            op_a_nxt  = wb_data;
            fwd_a_nxt = 2'd3;
        end
    end

    // Operand B source: same priority chain as A
    always_comb begin
        op_b_nxt  = PB;
        fwd_b_nxt = 2'd0;
        if (id_rs2 == '0) begin
            op_b_nxt  = '0;
            fwd_b_nxt = 2'd0;
        end else if (ex_valid && ex_rd_we && (ex_rd == id_rs2)) begin
            op_b_nxt  = ex_result;
            fwd_b_nxt = 2'd1;
        end else if (mem_we && (mem_rd == id_rs2)) begin
            op_b_nxt  = mem_result;
            fwd_b_nxt = 2'd2;
        end else if (wb_we && (wb_rd == id_rs2)) begin
            op_b_nxt  = wb_data;
            fwd_b_nxt = 2'd3;
        end
    end

    // Load-use hazard: load data is not ready until MEM, so hold ID for one cycle
    always_comb begin
        stall = id_valid && !flush && ex_valid && ex_is_load && ex_rd_we && (ex_rd != '0) &&
                ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
        bubble = flush || stall || !id_valid;
    end

    // EX pipeline register: bubble clears everything, otherwise capture ID
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid   <= 1'b0;
            ex_op_a    <= '0;
            ex_op_b    <= '0;
            ex_rd      <= '0;
            ex_rd_we   <= 1'b0;
            ex_is_load <= 1'b0;
            ex_fwd_a   <= 2'd0;
            ex_fwd_b   <= 2'd0;
        end else if (bubble) begin
            ex_valid   <= 1'b0;
            ex_op_a    <= '0;
            ex_op_b    <= '0;
            ex_rd      <= '0;
            ex_rd_we   <= 1'b0;
            ex_is_load <= 1'b0;
            ex_fwd_a   <= 2'd0;
            ex_fwd_b   <= 2'd0;
        end else begin
            ex_valid   <= 1'b1;
            ex_op_a    <= op_a_nxt;
            ex_op_b    <= op_b_nxt;
            ex_rd      <= id_rd;
            ex_rd_we   <= id_rd_we;
            ex_is_load <= id_is_load;
            ex_fwd_a   <= fwd_a_nxt;
            ex_fwd_b   <= fwd_b_nxt;
        end
    end

    // Stall cycle counter, saturating at all-ones
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - directed scoreboard bench for id_ex_operand_stage
module tb_id_ex_operand_stage;

    localparam int XLEN  = 32;
    localparam int AW    = 5;
    localparam int CNT_W = 16;
    localparam int SAT_W = 6;
    localparam int VW    = 1 + XLEN + 2 + XLEN + 2 + AW + 1 + 1;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            id_valid = 1'b0;
    logic [AW-1:0]   id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic            id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, id_rd_we = 1'b0, id_is_load = 1'b0;
    logic [XLEN-1:0] PA = '0, PB = '0, ex_result = '0, mem_result = '0, wb_data = '0;
    logic [AW-1:0]   mem_rd = '0, wb_rd = '0;
    logic            mem_we = 1'b0, wb_we = 1'b0, flush = 1'b0;

    logic             stall, ex_valid, ex_rd_we, ex_is_load;
    logic [XLEN-1:0]  ex_op_a, ex_op_b;
    logic [AW-1:0]    ex_rd;
    logic [1:0]       ex_fwd_a, ex_fwd_b;
    logic [CNT_W-1:0] stall_count;

    logic             s_stall, s_ex_valid, s_ex_rd_we, s_ex_is_load;
    logic [XLEN-1:0]  s_ex_op_a, s_ex_op_b;
    logic [AW-1:0]    s_ex_rd;
    logic [1:0]       s_ex_fwd_a, s_ex_fwd_b;
    logic [SAT_W-1:0] s_stall_count;

    int total = 0;
    int bad   = 0;
    logic [VW-1:0] sb_q[$];

    always #5 clk = ~clk;

    id_ex_operand_stage #(.XLEN(XLEN), .AW(AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_rd_we(id_rd_we),
        .id_is_load(id_is_load), .PA(PA), .PB(PB), .ex_result(ex_result), .mem_rd(mem_rd),
        .mem_we(mem_we), .mem_result(mem_result), .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data),
        .flush(flush), .stall(stall), .ex_valid(ex_valid), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
        .ex_rd(ex_rd), .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load), .ex_fwd_a(ex_fwd_a),
        .ex_fwd_b(ex_fwd_b), .stall_count(stall_count)
    );

    // Narrow-counter copy driven identically, so saturation is reachable in a short run
    id_ex_operand_stage #(.XLEN(XLEN), .AW(AW), .CNT_W(SAT_W)) u_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_rd_we(id_rd_we),
        .id_is_load(id_is_load), .PA(PA), .PB(PB), .ex_result(ex_result), .mem_rd(mem_rd),
        .mem_we(mem_we), .mem_result(mem_result), .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data),
        .flush(flush), .stall(s_stall), .ex_valid(s_ex_valid), .ex_op_a(s_ex_op_a), .ex_op_b(s_ex_op_b),
        .ex_rd(s_ex_rd), .ex_rd_we(s_ex_rd_we), .ex_is_load(s_ex_is_load), .ex_fwd_a(s_ex_fwd_a),
        .ex_fwd_b(s_ex_fwd_b), .stall_count(s_stall_count)
    );

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic [AW-1:0] rs1, input logic u1, input logic [AW-1:0] rs2,
                          input logic u2, input logic [AW-1:0] rd, input logic we, input logic ld);
        id_valid = 1'b1; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
        id_rd = rd; id_rd_we = we; id_is_load = ld;
    endtask

    task automatic push_exp(input logic v, input logic [XLEN-1:0] a, input logic [1:0] fa,
                            input logic [XLEN-1:0] b, input logic [1:0] fb,
                            input logic [AW-1:0] rd, input logic we, input logic ld);
        sb_q.push_back({v, a, fa, b, fb, rd, we, ld});
    endtask

    task automatic tick(input string tag);
        logic [VW-1:0] exp;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, '1, '0);
        end else begin
            exp = sb_q.pop_front();
            chk(tag, {ex_valid, ex_op_a, ex_fwd_a, ex_op_b, ex_fwd_b, ex_rd, ex_rd_we, ex_is_load}, exp);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ex_valid", VW'(ex_valid), VW'(0));
        chk("rst_outputs", VW'({ex_op_a, ex_op_b, ex_rd, ex_rd_we, ex_is_load, ex_fwd_a, ex_fwd_b}), VW'(0));
        chk("rst_count", VW'(stall_count), VW'(0));
        chk("rst_stall", VW'(stall), VW'(0));
        reset = 1'b0;

        // x0 protection: put an x0-writing instruction in EX, then read x0
        set_id(0, 1, 0, 0, 0, 1, 0); PA = 32'h55;
        push_exp(1, 0, 0, 0, 0, 0, 1, 0);
        tick("x0_setup");
        set_id(0, 1, 3, 1, 1, 1, 0); ex_result = 32'hDEADBEEF; PA = 32'h55; PB = 32'h77;
        push_exp(1, 0, 0, 32'h77, 0, 1, 1, 0);
        tick("x0_protect");

        // Forward priority on operand B: EX > MEM > WB > regfile
        set_id(0, 0, 0, 0, 5, 1, 0);
        push_exp(1, 0, 0, 0, 0, 5, 1, 0);
        tick("fwd_setup");
        set_id(0, 0, 5, 1, 6, 1, 0);
        ex_result = 32'h11; mem_rd = 5; mem_we = 1; mem_result = 32'h22;
        wb_rd = 5; wb_we = 1; wb_data = 32'h33; PB = 32'h44;
        push_exp(1, 0, 0, 32'h11, 1, 6, 1, 0);
        tick("fwd_ex");
        push_exp(1, 0, 0, 32'h22, 2, 6, 1, 0);
        tick("fwd_mem");
        mem_we = 0;
        push_exp(1, 0, 0, 32'h33, 3, 6, 1, 0);
        tick("fwd_wb");
        wb_we = 0;
        push_exp(1, 0, 0, 32'h44, 0, 6, 1, 0);
        tick("fwd_rf");

        // EX match with rd_we = 0 must fall through to MEM
        set_id(0, 0, 0, 0, 5, 0, 0);
        push_exp(1, 0, 0, 0, 0, 5, 0, 0);
        tick("nowe_setup");
        set_id(0, 0, 5, 1, 6, 1, 0); mem_rd = 5; mem_we = 1;
        push_exp(1, 0, 0, 32'h22, 2, 6, 1, 0);
        tick("nowe_fall_mem");
        mem_we = 0;

        // Load-use: one stall cycle, then the held instruction picks up MEM data
        set_id(0, 0, 0, 0, 7, 1, 1);
        push_exp(1, 0, 0, 0, 0, 7, 1, 1);
        tick("lu_load");
        set_id(7, 1, 0, 0, 8, 1, 0); ex_result = 32'hBAD;
        #1;
        chk("lu_stall", VW'(stall), VW'(1));
        push_exp(0, 0, 0, 0, 0, 0, 0, 0);
        tick("lu_bubble");
        chk("lu_count", VW'(stall_count), VW'(1));
        mem_rd = 7; mem_we = 1; mem_result = 32'hCAFE;
        #1;
        chk("lu_release", VW'(stall), VW'(0));
        push_exp(1, 32'hCAFE, 2, 0, 0, 8, 1, 0);
        tick("lu_mem_fwd");
        chk("lu_count2", VW'(stall_count), VW'(1));
        mem_we = 0;

        // Unused source never stalls
        set_id(0, 0, 0, 0, 7, 1, 1);
        push_exp(1, 0, 0, 0, 0, 7, 1, 1);
        tick("nfs_load");
        set_id(7, 0, 0, 0, 8, 1, 0); ex_result = 32'h99;
        #1;
        chk("nfs_stall", VW'(stall), VW'(0));
        push_exp(1, 32'h99, 1, 0, 0, 8, 1, 0);
        tick("nfs_advance");

        // Flush beats a load-use hazard
        set_id(0, 0, 0, 0, 7, 1, 1);
        push_exp(1, 0, 0, 0, 0, 7, 1, 1);
        tick("fl_load");
        set_id(7, 1, 0, 0, 8, 1, 0); flush = 1;
        #1;
        chk("fl_stall", VW'(stall), VW'(0));
        push_exp(0, 0, 0, 0, 0, 0, 0, 0);
        tick("fl_bubble");
        chk("fl_count", VW'(stall_count), VW'(1));
        flush = 0;

        // Repeated load-use pairs: narrow counter saturates, wide one keeps counting
        set_id(7, 1, 0, 0, 7, 1, 1); PA = 32'h5A;
        for (int i = 0; i < 67; i++) begin
            push_exp(1, 32'h5A, 0, 0, 0, 7, 1, 1);
            tick("sat_load");
            push_exp(0, 0, 0, 0, 0, 0, 0, 0);
            tick("sat_bubble");
        end
        chk("sat_narrow", VW'(s_stall_count), VW'(63));
        chk("sat_wide", VW'(stall_count), VW'(68));

        // Asynchronous reset in the middle of a stall
        push_exp(1, 32'h5A, 0, 0, 0, 7, 1, 1);
        tick("rst_load");
        chk("rst_pre_stall", VW'(stall), VW'(1));
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_stall", VW'(stall), VW'(0));
        chk("rst_mid_valid", VW'(ex_valid), VW'(0));
        chk("rst_mid_count", VW'(stall_count), VW'(0));
        chk("rst_mid_sat_count", VW'(s_stall_count), VW'(0));
        reset = 1'b0;
        id_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
